// File: rtl/sqrt_pkg.sv
// Shared types and constants for the odd-number integer square root.
// Holds the FSM state enum and the reset values of the square/delta registers.
package sqrt_pkg;

   typedef enum logic [1:0] {
      LOAD,
      COMPUTE,
      DONE
   } state_t;

   localparam int unsigned S_INIT = 1;
   localparam int unsigned D_INIT = 3;

endpackage

// File: rtl/sqrt_datapath.sv
// Datapath for the odd-number square root: operand, square, delta, root.
// Ports: i_boot (capture operand, init S/D/R), i_wr_root (R+=1),
//        i_wr_square (S+=D, D+=2), i_valor (radicand), o_le (S<=V),
//        o_root (current root R).
module sqrt_datapath
   import sqrt_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = IN_W / 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_boot,
   input  logic             i_wr_root,
   input  logic             i_wr_square,
   input  logic [IN_W-1:0]  i_valor,
   output logic             o_le,
   output logic [OUT_W-1:0] o_root
);

   localparam int SW = IN_W + 1;
   localparam int DW = OUT_W + 2;

   localparam logic [SW-1:0] SQ_INIT = SW'(S_INIT);
   localparam logic [DW-1:0] DL_INIT = DW'(D_INIT);

   logic [IN_W-1:0]  r_val;
   logic [SW-1:0]    r_sq;
   logic [DW-1:0]    r_dl;
   logic [OUT_W-1:0] r_root;

   logic [SW-1:0]    w_val_x;
   logic [SW-1:0]    w_dl_x;
   logic [SW-1:0]    w_sq_nx;
   logic [DW-1:0]    w_dl_nx;

   // S holds (R+1)^2; one extra bit so (2^OUT_W)^2 fits when R tops out.
   assign w_val_x = {1'b0, r_val};
   assign w_dl_x  = {{(SW - DW){1'b0}}, r_dl};
   assign w_sq_nx = r_sq + w_dl_x;
   assign w_dl_nx = r_dl + DW'(2);

   assign o_le   = (r_sq <= w_val_x);
   assign o_root = r_root;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_val  <= '0;
         r_sq   <= SQ_INIT;
         r_dl   <= DL_INIT;
         r_root <= '0;
      end else if (i_boot) begin
         r_val  <= i_valor;
         r_sq   <= SQ_INIT;
         r_dl   <= DL_INIT;
         r_root <= '0;
      end else begin
         if (i_wr_square) begin
            r_sq <= w_sq_nx;
            r_dl <= w_dl_nx;
         end
         if (i_wr_root) begin
            r_root <= r_root + OUT_W'(1);
         end
      end
   end

endmodule

// File: rtl/top_sqrt.sv
// Integer square root, floor(sqrt(valor_i)), by odd-number iteration.
// Ports: clk, rst_n (async, active-low), valor_i (radicand),
//        ready_o (1 while busy, 0 when root_o valid), root_o (root),
//        cycles_o (busy-cycle count, only with SQRT_CYCLE_COUNT_EN).
// A new computation starts only on reset release; DONE holds forever.
module top_sqrt
   import sqrt_pkg::*;
#(
   parameter  int IN_W  = 16,
   localparam int OUT_W = IN_W / 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  valor_i,
   output logic             ready_o,
   output logic [OUT_W-1:0] root_o
`ifdef SQRT_CYCLE_COUNT_EN
   ,
   output logic [OUT_W:0]   cycles_o
`endif
);

   state_t r_state;
   state_t w_next;

   logic w_boot;
   logic w_wr_root;
   logic w_wr_square;
   logic w_le;
   logic w_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= LOAD;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_boot      = 1'b0;
      w_wr_root   = 1'b0;
      w_wr_square = 1'b0;
      w_busy      = 1'b1;
      unique case (r_state)
         LOAD: begin
            w_boot = 1'b1;
            w_next = COMPUTE;
         end
         COMPUTE: begin
            // The final failing compare costs one cycle with no update.
            if (w_le) begin
               w_wr_root   = 1'b1;
               w_wr_square = 1'b1;
            end else begin
               w_next = DONE;
            end
         end
         DONE: begin
            w_busy = 1'b0;
         end
         default: begin
            w_next = LOAD;
         end
      endcase
   end

   assign ready_o = w_busy;

   sqrt_datapath #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_dp (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_boot      (w_boot),
      .i_wr_root   (w_wr_root),
      .i_wr_square (w_wr_square),
      .i_valor     (valor_i),
      .o_le        (w_le),
      .o_root      (root_o)
   );

`ifdef SQRT_CYCLE_COUNT_EN
   logic [OUT_W:0] r_cycles;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycles <= '0;
      end else if (w_busy) begin
         r_cycles <= r_cycles + (OUT_W + 1)'(1);
      end
   end

   assign cycles_o = r_cycles;
`endif

endmodule

// File: tb/tb_top_sqrt.sv
// Directed self-checking bench for top_sqrt (IN_W=16).
// Checks reset state, roots, busy latency, abort and DONE hold.
module tb_top_sqrt;

   localparam int IN_W  = 16;
   localparam int OUT_W = IN_W / 2;

   logic             clk;
   logic             rst_n;
   logic [IN_W-1:0]  valor_i;
   logic             ready_o;
   logic [OUT_W-1:0] root_o;
`ifdef SQRT_CYCLE_COUNT_EN
   logic [OUT_W:0]   cycles_o;
`endif

   int nvec;
   int nerr;

   top_sqrt #(
      .IN_W (IN_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .valor_i (valor_i),
      .ready_o (ready_o),
      .root_o  (root_o)
`ifdef SQRT_CYCLE_COUNT_EN
      ,
      .cycles_o (cycles_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference root by binary search on the square.
   function automatic int isqrt(input int v);
      int lo;
      int hi;
      int mid;
      lo = 0;
      hi = 256;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (mid * mid <= v) lo = mid;
         else hi = mid;
      end
      return lo;
   endfunction

   // Assert reset mid-cycle, check reset outputs, release on a negedge.
   task automatic do_reset(input int v);
      @(negedge clk);
      valor_i = IN_W'(v);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_root", 32'(root_o), 32'd0);
`ifdef SQRT_CYCLE_COUNT_EN
      chk("rst_cycles", 32'(cycles_o), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Count rising edges until ready_o drops (bounded), then check.
   task automatic wait_done(input string tag,
                            input int exp_root,
                            input int exp_lat);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      while (!done && n < 600) begin
         @(posedge clk);
         #1;
         n++;
         if (!ready_o) done = 1'b1;
      end
      chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
      chk({tag, "_root"}, 32'(root_o), 32'(exp_root));
`ifdef SQRT_CYCLE_COUNT_EN
      chk({tag, "_cyc"}, 32'(cycles_o), 32'(exp_root + 2));
`endif
   endtask

   initial begin
      int sq[10];
      int k;
      int v;
      nvec    = 0;
      nerr    = 0;
      rst_n   = 1'b0;
      valor_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_ready", 32'(ready_o), 32'd1);
      chk("init_root", 32'(root_o), 32'd0);

      do_reset(0);
      wait_done("v0", 0, 2);

      do_reset(16);
      wait_done("v16", 4, 6);

      // DONE holds with the clock running
      repeat (5) @(posedge clk);
      #1;
      chk("hold_root", 32'(root_o), 32'd4);
      chk("hold_ready", 32'(ready_o), 32'd0);
`ifdef SQRT_CYCLE_COUNT_EN
      chk("hold_cyc", 32'(cycles_o), 32'd6);
`endif

      do_reset(15);
      wait_done("v15", 3, 5);

      do_reset(17);
      wait_done("v17", 4, 6);

      do_reset(65535);
      wait_done("vmax", 255, 257);

      // Operand changes after LOAD are ignored
      do_reset(16);
      @(posedge clk);
      #1;
      valor_i = 16'hFFFF;
      wait_done("late_in", 4, 5);

      // Abort mid-computation, then restart with 100
      do_reset(65535);
      repeat (50) @(posedge clk);
      #1;
      chk("abort_busy", 32'(ready_o), 32'd1);
      do_reset(100);
      wait_done("v100", 10, 12);

      // Abort from DONE
      do_reset(9);
      wait_done("v9", 3, 5);
      do_reset(2);
      wait_done("v2", 1, 3);

      // Dense low sweep
      for (int i = 0; i < 300; i++) begin
         do_reset(i);
         wait_done("sweep", isqrt(i), isqrt(i) + 2);
      end

      // Neighbours of selected perfect squares
      sq = '{15, 31, 64, 100, 127, 128, 181, 200, 254, 255};
      for (int j = 0; j < 10; j++) begin
         k = sq[j];
         for (int d = -1; d <= 1; d++) begin
            v = k * k + d;
            do_reset(v);
            wait_done("sq", isqrt(v), isqrt(v) + 2);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
